// File: rtl/riscv_retire_status.sv
// Retire-point status producer: retired-instruction count, per-instruction result, sticky halt.
// Optional idle watchdog enabled by defining STATUS_WATCHDOG_EN.
module riscv_retire_status #(
    parameter logic [31:0] HALT_INST0     = 32'h00c00093,
    parameter logic [31:0] HALT_INST1     = 32'h00008067,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        RET_VALID,
    input  logic [31:0] RET_INST,
    input  logic        RET_IS_BRANCH,
    input  logic        RET_BR_TAKEN,
    input  logic        RET_IS_STORE,
    input  logic [31:0] RET_MEM_ADDR,
    input  logic        RET_RF_WE,
    input  logic [31:0] RET_RF_WD,
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ARMED,
        ST_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] num_inst_q, num_inst_d;
    logic [31:0] out_q, out_d;
    logic        halt_q, halt_d;
    logic        counted;

`ifdef STATUS_WATCHDOG_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        num_inst_d = num_inst_q;
        out_d      = out_q;
        // The second halt word is swallowed only when it directly follows the first.
        counted    = RET_VALID && (state_q != ST_HALTED)
                     && !((state_q == ST_ARMED) && (RET_INST == HALT_INST1));

        if (counted) begin
            num_inst_d = num_inst_q + 32'd1;
            if (RET_IS_BRANCH) begin
                out_d = {31'b0, RET_BR_TAKEN};
            end else if (RET_IS_STORE) begin
                out_d = RET_MEM_ADDR;
            end else if (RET_RF_WE) begin
                out_d = RET_RF_WD;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (counted && (RET_INST == HALT_INST0)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (RET_VALID) begin
                    if (RET_INST == HALT_INST1) begin
                        state_d = ST_HALTED;
                    end else if (RET_INST != HALT_INST0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_HALTED;
        endcase

`ifdef STATUS_WATCHDOG_EN
        idle_d = idle_q;
        if (state_q != ST_HALTED) begin
            if (RET_VALID) begin
                idle_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
                // This idle cycle brings the count to the limit.
                if (idle_q == IDLE_LAST) begin
                    state_d = ST_HALTED;
                end
            end
        end
`endif

        halt_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_RUN;
            num_inst_q <= '0;
            out_q      <= '0;
            halt_q     <= 1'b0;
`ifdef STATUS_WATCHDOG_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            num_inst_q <= num_inst_d;
            out_q      <= out_d;
            halt_q     <= halt_d;
`ifdef STATUS_WATCHDOG_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign NUM_INST    = num_inst_q;
    assign OUTPUT_PORT = out_q;
    assign HALT        = halt_q;

endmodule
